smc_seq_ctrl: RTL and testbench

Sequential controller for the transistor current/transconductance calculator. It collects six transistor descriptors (W, V_GS, V_DS) serially over a valid-qualified input stream and computes each device's drain current or transconductance in a per-beat calculation unit. It keeps a running sorted list of the six results and emits the sum of the three largest or three smallest as a single-cycle result pulse. It sits between the stimulus/host interface and the result sink, replacing the fully parallel six-port form with a one-port-per-cycle scheduled datapath.

---
 rtl/smc_pkg.sv | 29 ++
 rtl/smc_dev_calc.sv | 56 +++++
 rtl/smc_seq_ctrl.sv | 145 ++++++++++++++
 tb/tb_smc_seq_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/smc_pkg.sv
// Shared constants, mode bit indices and FSM state encoding for the
// smc_seq_ctrl current/transconductance sequencer.
package smc_pkg;

    localparam int NUM_T          = 6;
    localparam int VAL_W          = 7;
    localparam int OUT_W          = 10;
    localparam int CNT_W          = 3;
    localparam int VTH            = 1;
    localparam int MODE_ID_BIT    = 0;
    localparam int MODE_LARGE_BIT = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SUM  = 2'd2,
        OUT  = 2'd3
    } state_t;

    // Zero-extended three-operand sum; 3 * 84 = 252 always fits OUT_W.
    function automatic logic [OUT_W-1:0] sum3(
        input logic [VAL_W-1:0] a,
        input logic [VAL_W-1:0] b,
        input logic [VAL_W-1:0] c
    );
        return OUT_W'(a) + OUT_W'(b) + OUT_W'(c);
    endfunction

endpackage

// File: rtl/smc_dev_calc.sv
// Combinational per-device I_D / g_m calculator with region decode.
// Define SMC_SEQ_ROUND_EN to round the divide-by-3 to nearest.
module smc_dev_calc
    import smc_pkg::*;
(
    input  logic [2:0]       w,
    input  logic [2:0]       v_gs,
    input  logic [2:0]       v_ds,
    input  logic             sel_id,
    output logic [VAL_W-1:0] val
);

    localparam int CW = 10;

    logic [CW-1:0] w_s;
    logic [CW-1:0] ds_s;
    logic [CW-1:0] ov_s;
    logic [CW-1:0] num_s;

    // Region decode and numerator before the divide by 3.
    always_comb begin
        w_s   = CW'(w);
        ds_s  = CW'(v_ds);
        ov_s  = '0;
        num_s = '0;
        if (v_gs > 3'(VTH)) begin
            ov_s = CW'(v_gs) - CW'(VTH);
            if (ov_s > ds_s) begin
                // Triode: V_DS < V_ov, so 2*V_ov*V_DS - V_DS^2 cannot underflow.
                if (sel_id) begin
                    num_s = w_s * (CW'(2) * ov_s * ds_s - ds_s * ds_s);
                end else begin
                    num_s = CW'(2) * w_s * ds_s;
                end
            end else begin
                if (sel_id) begin
                    num_s = w_s * ov_s * ov_s;
                end else begin
                    num_s = CW'(2) * w_s * ov_s;
                end
            end
        end else begin
            num_s = '0;
        end
    end

    // Divide by 3; rounded variant adds 1 before truncation.
    always_comb begin
`ifdef SMC_SEQ_ROUND_EN
        val = VAL_W'((num_s + CW'(1)) / CW'(3));
`else
        val = VAL_W'(num_s / CW'(3));
`endif
    end

endmodule

// File: rtl/smc_seq_ctrl.sv
// Sequential six-device controller: serial descriptor intake, running
// descending insertion sort, and a three-entry sum pulse. Option macro: SMC_SEQ_ROUND_EN.
module smc_seq_ctrl
    import smc_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       mode,
    input  logic [2:0]       W,
    input  logic [2:0]       V_GS,
    input  logic [2:0]       V_DS,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_n
);

    state_t                      state_r;
    logic [CNT_W-1:0]            cnt_r;
    logic [1:0]                  mode_r;
    logic [NUM_T-1:0][VAL_W-1:0] arr_r;
    logic [OUT_W-1:0]            sum_r;

    logic                        sel_id_s;
    logic                        accept_s;
    logic [VAL_W-1:0]            dev_val_s;
    logic [NUM_T-1:0]            ge_s;
    logic [NUM_T-1:0][VAL_W-1:0] ins_arr_s;
    logic [OUT_W-1:0]            sum_s;

    assign accept_s = in_valid && in_ready;

    // The first beat has no latched mode yet, so it uses the live mode bit.
    always_comb begin
        if (state_r == IDLE) begin
            sel_id_s = mode[MODE_ID_BIT];
        end else begin
            sel_id_s = mode_r[MODE_ID_BIT];
        end
    end

    smc_dev_calc u_dev_calc (
        .w      (W),
        .v_gs   (V_GS),
        .v_ds   (V_DS),
        .sel_id (sel_id_s),
        .val    (dev_val_s)
    );

    // Insert after every valid entry >= new value, so ties keep arrival order.
    always_comb begin
        ge_s      = '0;
        ins_arr_s = arr_r;
        for (int i = 0; i < NUM_T; i++) begin
            ge_s[i] = (CNT_W'(i) < cnt_r) && (arr_r[i] >= dev_val_s);
        end
        if (ge_s[0]) begin
            ins_arr_s[0] = arr_r[0];
        end else begin
            ins_arr_s[0] = dev_val_s;
        end
        for (int i = 1; i < NUM_T; i++) begin
            if (ge_s[i]) begin
                ins_arr_s[i] = arr_r[i];
            end else if (ge_s[i-1]) begin
                ins_arr_s[i] = dev_val_s;
            end else begin
                ins_arr_s[i] = arr_r[i-1];
            end
        end
    end

    // Select the largest or smallest three entries.
    always_comb begin
        if (mode_r[MODE_LARGE_BIT]) begin
            sum_s = sum3(arr_r[0], arr_r[1], arr_r[2]);
        end else begin
            sum_s = sum3(arr_r[3], arr_r[4], arr_r[5]);
        end
    end

    // Burst FSM with registered handshake and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            cnt_r     <= '0;
            mode_r    <= 2'b00;
            arr_r     <= '0;
            sum_r     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_n     <= '0;
        end else begin
            out_valid <= 1'b0;
            out_n     <= '0;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        mode_r  <= mode;
                        arr_r   <= ins_arr_s;
                        cnt_r   <= CNT_W'(1);
                        state_r <= LOAD;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                LOAD: begin
                    if (accept_s) begin
                        arr_r <= ins_arr_s;
                        cnt_r <= cnt_r + CNT_W'(1);
                        if (cnt_r == CNT_W'(NUM_T - 1)) begin
                            state_r  <= SUM;
                            in_ready <= 1'b0;
                        end else begin
                            state_r <= LOAD;
                        end
                    end else begin
                        state_r <= LOAD;
                    end
                end
                SUM: begin
                    sum_r   <= sum_s;
                    state_r <= OUT;
                end
                OUT: begin
                    out_valid <= 1'b1;
                    out_n     <= sum_r;
                    arr_r     <= '0;
                    cnt_r     <= '0;
                    mode_r    <= 2'b00;
                    in_ready  <= 1'b1;
                    state_r   <= IDLE;
                end
                default: begin
                    arr_r    <= '0;
                    cnt_r    <= '0;
                    mode_r   <= 2'b00;
                    in_ready <= 1'b1;
                    state_r  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_smc_seq_ctrl.sv
// Scoreboard bench for smc_seq_ctrl: expected sums are queued when a burst
// is driven and checked when out_valid pulses.
module tb_smc_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [2:0] W = 3'd0;
    logic [2:0] V_GS = 3'd0;
    logic [2:0] V_DS = 3'd0;
    logic       in_ready;
    logic       out_valid;
    logic [9:0] out_n;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_acc = 0;
    int want_q[$];
    int bw[6];
    int bg[6];
    int bd[6];

    smc_seq_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .W         (W),
        .V_GS      (V_GS),
        .V_DS      (V_DS),
        .out_valid (out_valid),
        .out_n     (out_n)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, want);
        end
    endtask

    function automatic int dev_model(input int w, input int g, input int d, input bit id);
        int ov;
        int num;
        if (g <= 1) return 0;
        ov = g - 1;
        if (ov > d) num = id ? w * (2 * ov * d - d * d) : 2 * w * d;
        else        num = id ? w * ov * ov : 2 * w * ov;
`ifdef SMC_SEQ_ROUND_EN
        return (num + 1) / 3;
`else
        return num / 3;
`endif
    endfunction

    function automatic int burst_model(input bit [1:0] m);
        int v[6];
        int t;
        for (int i = 0; i < 6; i++) v[i] = dev_model(bw[i], bg[i], bd[i], m[0]);
        for (int i = 0; i < 6; i++)
            for (int j = i + 1; j < 6; j++)
                if (v[j] > v[i]) begin
                    t = v[i]; v[i] = v[j]; v[j] = t;
                end
        return m[1] ? (v[0] + v[1] + v[2]) : (v[3] + v[4] + v[5]);
    endfunction

    task automatic set_std();
        bw = '{7, 3, 3, 1, 1, 3};
        bg = '{7, 3, 4, 1, 1, 3};
        bd = '{7, 3, 1, 0, 0, 3};
    endtask

    task automatic set_all(input int w, input int g, input int d);
        for (int i = 0; i < 6; i++) begin
            bw[i] = w; bg[i] = g; bd[i] = d;
        end
    endtask

    // Called at a negedge; returns at the negedge after acceptance.
    task automatic send_beat(input int w, input int g, input int d, input bit [1:0] m);
        W = 3'(w); V_GS = 3'(g); V_DS = 3'(d); mode = m; in_valid = 1'b1;
        for (int t = 0; t < 20 && !in_ready; t++) @(negedge clk);
        if (!in_ready) check("ready_timeout", 0, 1);
        @(posedge clk);
        #1 last_acc = cyc;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_burst(input bit [1:0] m0, input bit toggle, input int gap);
        bit [1:0] m;
        want_q.push_back(burst_model(m0));
        for (int i = 0; i < 6; i++) begin
            m = (toggle && i > 0) ? ((i % 2 == 1) ? ~m0 : m0 ^ 2'b01) : m0;
            send_beat(bw[i], bg[i], bd[i], m);
            if (i == 1) repeat (gap) @(negedge clk);
        end
    endtask

    task automatic wait_done();
        for (int t = 0; t < 20 && want_q.size() != 0; t++) @(negedge clk);
        if (want_q.size() != 0) begin
            check("result_timeout", want_q.size(), 0);
            want_q.delete();
        end
    endtask

    // Output monitor: pops the scoreboard on each pulse, otherwise out_n must be 0.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                if (want_q.size() == 0) begin
                    check("unexpected_pulse", 1, 0);
                end else begin
                    check("out_n", int'(out_n), want_q.pop_front());
                    check("latency", cyc - last_acc, 2);
                end
            end else begin
                check("idle_out_n", int'(out_n), 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_n", int'(out_n), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", int'(in_ready), 1);

        set_std();
        send_burst(2'b11, 1'b0, 0); wait_done();
        send_burst(2'b01, 1'b0, 0); wait_done();
        send_burst(2'b10, 1'b0, 0); wait_done();
        send_burst(2'b00, 1'b0, 0); wait_done();

        // Gap of 3 idle cycles after beat 2; later beats carry other modes.
        send_burst(2'b11, 1'b1, 3); wait_done();

        // Keep in_valid high through SUM and OUT; those beats must be dropped.
        send_burst(2'b11, 1'b0, 0);
        W = 3'd7; V_GS = 3'd7; V_DS = 3'd7; mode = 2'b11; in_valid = 1'b1;
        check("sum_in_ready", int'(in_ready), 0);
        @(negedge clk);
        check("out_in_ready", int'(in_ready), 0);
        @(negedge clk);
        in_valid = 1'b0;
        check("ready_back", int'(in_ready), 1);
        wait_done();
        set_all(7, 7, 7);
        send_burst(2'b11, 1'b0, 0); wait_done();

        // Saturation with V_ov = 1: exercises the divide/round path.
        set_all(5, 2, 7);
        send_burst(2'b11, 1'b0, 0); wait_done();

        // Abort after four beats; nothing of that burst may appear.
        set_std();
        for (int i = 0; i < 4; i++) send_beat(bw[i], bg[i], bd[i], 2'b11);
        rst_n = 1'b0;
        #1;
        check("abort_in_ready", int'(in_ready), 1);
        check("abort_out_valid", int'(out_valid), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        set_all(3, 3, 3);
        send_burst(2'b11, 1'b0, 0); wait_done();

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
